// File: rtl/bubble_gate_pipe_pkg.sv
// Shared constants for bubble_gate_pipe: gate function encodings and stats counter width.
package bubble_gate_pipe_pkg;

  localparam int unsigned GATE_MODE_W = 3;
  localparam int unsigned STATS_W     = 16;

  localparam logic [GATE_MODE_W-1:0] GM_AND  = 3'd0;
  localparam logic [GATE_MODE_W-1:0] GM_OR   = 3'd1;
  localparam logic [GATE_MODE_W-1:0] GM_XOR  = 3'd2;
  localparam logic [GATE_MODE_W-1:0] GM_NAND = 3'd3;
  localparam logic [GATE_MODE_W-1:0] GM_NOR  = 3'd4;
  localparam logic [GATE_MODE_W-1:0] GM_XNOR = 3'd5;
  localparam logic [GATE_MODE_W-1:0] GM_PASS = 3'd6;
  localparam logic [GATE_MODE_W-1:0] GM_ZERO = 3'd7;

endpackage

// File: rtl/bubble_gate_pipe_if.sv
// Valid/ready bus for bubble_gate_pipe: upstream word set plus downstream reduced result.
interface bubble_gate_pipe_if #(
  parameter int unsigned NR_OF_INPUTS = 4,
  parameter int unsigned NR_OF_BITS   = 8
);

  logic                               in_valid;
  logic                               in_ready;
  logic [NR_OF_INPUTS*NR_OF_BITS-1:0] data_in;
  logic [NR_OF_INPUTS-1:0]            bubbles_mask;
  logic [2:0]                         gate_mode;
  logic                               out_valid;
  logic                               out_ready;
  logic [NR_OF_BITS-1:0]              result;

  modport master (
    output in_valid, data_in, bubbles_mask, gate_mode, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, data_in, bubbles_mask, gate_mode, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/bubble_gate_pipe_stage.sv
// One valid/ready register stage; data is only overwritten by a valid word so it holds across bubbles.
module bubble_gate_pipe_stage #(
  parameter int unsigned NR_OF_BITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  up_valid,
  input  logic [NR_OF_BITS-1:0] up_data,
  output logic                  valid,
  output logic [NR_OF_BITS-1:0] data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/bubble_gate_pipe.sv
// Bubbled N-input logic reduction feeding a PIPE_DEPTH valid/ready register pipeline.
// Optional accept/stall counters are enabled with BUBBLE_GATE_PIPE_STATS_EN.
module bubble_gate_pipe
  import bubble_gate_pipe_pkg::*;
#(
  parameter int unsigned NR_OF_INPUTS = 4,
  parameter int unsigned NR_OF_BITS   = 8,
  parameter int unsigned PIPE_DEPTH   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef BUBBLE_GATE_PIPE_STATS_EN
  output logic [STATS_W-1:0]   accept_count,
  output logic [STATS_W-1:0]   stall_count,
`endif
  bubble_gate_pipe_if.slave    bus
);

  localparam int unsigned DATA_W = NR_OF_INPUTS * NR_OF_BITS;

  function automatic logic [NR_OF_BITS-1:0] reduce_words(
    input logic [DATA_W-1:0]       words,
    input logic [NR_OF_INPUTS-1:0] mask,
    input logic [GATE_MODE_W-1:0]  mode
  );
    logic [NR_OF_BITS-1:0] w;
    logic [NR_OF_BITS-1:0] and_acc;
    logic [NR_OF_BITS-1:0] or_acc;
    logic [NR_OF_BITS-1:0] xor_acc;
    logic [NR_OF_BITS-1:0] first;
    logic [NR_OF_BITS-1:0] res;
    and_acc = '1;
    or_acc  = '0;
    xor_acc = '0;
    first   = '0;
    for (int unsigned i = 0; i < NR_OF_INPUTS; i++) begin
      w       = words[i*NR_OF_BITS +: NR_OF_BITS] ^ {NR_OF_BITS{mask[i]}};
      and_acc = and_acc & w;
      or_acc  = or_acc | w;
      xor_acc = xor_acc ^ w;
      if (i == 0) begin
        first = w;
      end
    end
    case (mode)
      GM_AND:  res = and_acc;
      GM_OR:   res = or_acc;
      GM_XOR:  res = xor_acc;
      GM_NAND: res = ~and_acc;
      GM_NOR:  res = ~or_acc;
      GM_XNOR: res = ~xor_acc;
      GM_PASS: res = first;
      default: res = '0;
    endcase
    return res;
  endfunction

  logic                  live;
  logic                  accept;
  logic [PIPE_DEPTH-1:0] stage_load;
  logic [PIPE_DEPTH-1:0] stage_valid;
  logic [NR_OF_BITS-1:0] stage_data [PIPE_DEPTH];

  // Holds in_ready low through reset and the first cycle after it.
  always_ff @(posedge clock) begin
    if (reset) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  // A stage loads when empty or when its successor loads; this collapses interior bubbles.
  always_comb begin
    stage_load = '0;
    stage_load[PIPE_DEPTH-1] = !stage_valid[PIPE_DEPTH-1] || bus.out_ready;
    for (int k = int'(PIPE_DEPTH) - 2; k >= 0; k--) begin
      stage_load[k] = !stage_valid[k] || stage_load[k+1];
    end
  end

  assign bus.in_ready  = live && !reset && stage_load[0];
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = stage_valid[PIPE_DEPTH-1];
  assign bus.result    = stage_data[PIPE_DEPTH-1];

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    logic                  up_valid;
    logic [NR_OF_BITS-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = accept;
      assign up_data  = reduce_words(bus.data_in, bus.bubbles_mask, bus.gate_mode);
    end else begin : g_body
      assign up_valid = stage_valid[k-1];
      assign up_data  = stage_data[k-1];
    end

    bubble_gate_pipe_stage #(
      .NR_OF_BITS (NR_OF_BITS)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .load     (stage_load[k]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .valid    (stage_valid[k]),
      .data     (stage_data[k])
    );
  end

`ifdef BUBBLE_GATE_PIPE_STATS_EN
  // Free-running wrap-around event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      accept_count <= '0;
      stall_count  <= '0;
    end else begin
      if (accept) begin
        accept_count <= accept_count + STATS_W'(1);
      end
      if (bus.out_valid && !bus.out_ready) begin
        stall_count <= stall_count + STATS_W'(1);
      end
    end
  end
`endif

endmodule
